// File: rtl/clock_run_pkg.sv
// Shared types for the clock/reset/run-length sequencer.
package clock_run_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states; encodings are visible on the state output.
    typedef enum logic [STATE_W-1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_DONE   = 2'd3
    } run_state_e;

    // Width of a counter that must reach hold-1 (at least one bit).
    function automatic int unsigned hold_width(input int unsigned hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/clk_phase_div.sv
// Power-of-two divider producing a phase-masked, registered clock vector.
module clk_phase_div #(
    parameter int unsigned          NUM_CLK    = 4,
    parameter int unsigned          DIV_LOG2   = 1,
    parameter logic [NUM_CLK-1:0]   PHASE_MASK = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    output logic               o_boundary_c,
    output logic [NUM_CLK-1:0] o_clk_out
);

    localparam logic [DIV_LOG2-1:0] DIV_LAST = '1;

    logic [DIV_LOG2-1:0] r_div_cnt;
    logic [DIV_LOG2-1:0] w_div_next;
    logic                w_phase;

    // Counter only moves while enabled; it rests at 0 otherwise.
    assign w_div_next   = i_enable ? (r_div_cnt + DIV_LOG2'(1)) : r_div_cnt;
    assign o_boundary_c = i_enable && (r_div_cnt == DIV_LAST);
    assign w_phase      = w_div_next[DIV_LOG2-1];

    // Divider state and registered clock outputs follow the next count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            o_clk_out <= PHASE_MASK;
        end else begin
            r_div_cnt <= w_div_next;
            o_clk_out <= {NUM_CLK{w_phase}} ^ PHASE_MASK;
        end
    end

endmodule

// File: rtl/clock_run_sequencer.sv
// Reset-hold window, divided clock generation and bounded run control.
module clock_run_sequencer
    import clock_run_pkg::*;
#(
    parameter int unsigned          NUM_CLK    = 4,
    parameter int unsigned          DIV_LOG2   = 1,
    parameter logic [NUM_CLK-1:0]   PHASE_MASK = '0,
    parameter int unsigned          RESET_HOLD = 2,
    parameter int unsigned          RUN_CYCLES = 200,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               halt,
    output logic [NUM_CLK-1:0] clk_out,
    output logic               sys_reset,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               run_done,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned         HOLD_W      = hold_width(RESET_HOLD);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
    localparam bit                  RUN_LIMITED = (RUN_CYCLES != 0);

    run_state_e          r_state;
    run_state_e          w_state_next;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_next;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [CNT_W-1:0]    w_cycle_next;
    logic                r_sys_reset;
    logic                w_sys_reset_next;
    logic                r_run_done;
    logic                w_run_done_next;
    logic                w_run_en;
    logic                w_boundary;
    logic                w_final;

    assign w_run_en = (r_state == ST_RUN);

    // Final period: the count about to complete equals the run length.
    assign w_final = RUN_LIMITED &&
                     ((64'(r_cycle_count) + 64'd1) == 64'(RUN_CYCLES));

    clk_phase_div #(
        .NUM_CLK    (NUM_CLK),
        .DIV_LOG2   (DIV_LOG2),
        .PHASE_MASK (PHASE_MASK)
    ) u_div (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_enable     (w_run_en),
        .o_boundary_c (w_boundary),
        .o_clk_out    (clk_out)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_sys_reset   <= 1'b1;
            r_run_done    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold_cnt    <= w_hold_next;
            r_cycle_count <= w_cycle_next;
            r_sys_reset   <= w_sys_reset_next;
            r_run_done    <= w_run_done_next;
        end
    end

    // Next-state logic; DONE outranks a halt request on the last boundary.
    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold_cnt;
        w_cycle_next     = r_cycle_count;
        w_sys_reset_next = r_sys_reset;
        w_run_done_next  = r_run_done;
        case (r_state)
            ST_HOLD: begin
                w_hold_next = r_hold_cnt + HOLD_W'(1);
                if (r_hold_cnt == HOLD_LAST) begin
                    w_sys_reset_next = 1'b0;
                    w_state_next     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_boundary) begin
                    if (r_cycle_count != CNT_MAX) begin
                        w_cycle_next = r_cycle_count + CNT_W'(1);
                    end
                    if (w_final) begin
                        w_state_next    = ST_DONE;
                        w_run_done_next = 1'b1;
                    end else if (halt) begin
                        w_state_next = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_HOLD;
            end
        endcase
    end

    assign sys_reset   = r_sys_reset;
    assign cycle_count = r_cycle_count;
    assign run_done    = r_run_done;
    assign state       = r_state;

endmodule

// File: tb/tb_clock_run_sequencer.sv
// Randomized self-checking bench for clock_run_sequencer (two configurations).
module tb_clock_run_sequencer;

    localparam int          A_P    = 2;
    localparam int          A_RH   = 2;
    localparam int          A_RC   = 200;
    localparam logic [3:0]  A_MASK = 4'b0000;
    localparam int          B_P    = 4;
    localparam int          B_RH   = 3;
    localparam int          B_RC   = 40;
    localparam logic [3:0]  B_MASK = 4'b0101;
    localparam int          CMAX   = 65535;

    logic        clock = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        halt_a = 1'b0;
    logic        halt_b = 1'b0;
    logic [3:0]  clk_a, clk_b;
    logic        sysr_a, sysr_b;
    logic [15:0] cnt_a, cnt_b;
    logic        done_a, done_b;
    logic [1:0]  state_a, state_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit done_edge_chk = 1'b1;
    int a_edges = 0;
    int hi_len = 0;

    always #5 clock = ~clock;

    clock_run_sequencer #(
        .NUM_CLK(4), .DIV_LOG2(1), .PHASE_MASK(A_MASK),
        .RESET_HOLD(A_RH), .RUN_CYCLES(A_RC), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(rst_a), .halt(halt_a), .clk_out(clk_a),
        .sys_reset(sysr_a), .cycle_count(cnt_a), .run_done(done_a), .state(state_a)
    );

    clock_run_sequencer #(
        .NUM_CLK(4), .DIV_LOG2(2), .PHASE_MASK(B_MASK),
        .RESET_HOLD(B_RH), .RUN_CYCLES(B_RC), .CNT_W(16)
    ) dut_b (
        .clock(clock), .reset(rst_b), .halt(halt_b), .clk_out(clk_b),
        .sys_reset(sysr_b), .cycle_count(cnt_b), .run_done(done_b), .state(state_b)
    );

    // Behavioural model: mode 0..3, edges spent in HOLD, position within period.
    typedef struct {
        int mode;
        int hold;
        int ph;
        int cnt;
        int done;
        int sysr;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.mode = 0; m.hold = 0; m.ph = 0; m.cnt = 0; m.done = 0; m.sysr = 1;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input logic h,
                                          input int rh, input int p, input int rc);
        model_t n;
        n = m;
        case (m.mode)
            0: begin
                n.hold = m.hold + 1;
                if (n.hold == rh) begin
                    n.mode = 1;
                    n.sysr = 0;
                end
            end
            1: begin
                n.ph = m.ph + 1;
                if (n.ph == p) begin
                    n.ph  = 0;
                    n.cnt = (m.cnt < CMAX) ? m.cnt + 1 : CMAX;
                    if (rc != 0 && m.cnt + 1 == rc) begin
                        n.mode = 3;
                        n.done = 1;
                    end else if (h) begin
                        n.mode = 2;
                    end
                end
            end
            2: if (!h) n.mode = 1;
            default: n = m;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] exp_clk(input model_t m, input int p, input logic [3:0] mask);
        return (m.ph >= p / 2) ? ~mask : mask;
    endfunction

    model_t ma, mb;

    always @(posedge clock or posedge rst_a) begin
        if (rst_a) ma <= model_reset();
        else       ma <= model_step(ma, halt_a, A_RH, A_P, A_RC);
    end

    always @(posedge clock or posedge rst_b) begin
        if (rst_b) mb <= model_reset();
        else       mb <= model_step(mb, halt_b, B_RH, B_P, B_RC);
    end

    always @(posedge clock or posedge rst_a) begin
        if (rst_a) a_edges <= 0;
        else       a_edges <= a_edges + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Per-cycle comparison against the model, plus edge-anchored run-length checks.
    always @(posedge clock) begin
        #1;
        if (cmp_en) begin
            check("a_state", 32'(state_a), 32'(ma.mode));
            check("a_sys_reset", 32'(sysr_a), 32'(ma.sysr));
            check("a_run_done", 32'(done_a), 32'(ma.done));
            check("a_cycle_count", 32'(cnt_a), 32'(ma.cnt));
            check("a_clk_out", 32'(clk_a), 32'(exp_clk(ma, A_P, A_MASK)));
            check("b_state", 32'(state_b), 32'(mb.mode));
            check("b_sys_reset", 32'(sysr_b), 32'(mb.sysr));
            check("b_run_done", 32'(done_b), 32'(mb.done));
            check("b_cycle_count", 32'(cnt_b), 32'(mb.cnt));
            check("b_clk_out", 32'(clk_b), 32'(exp_clk(mb, B_P, B_MASK)));
            if (done_edge_chk && a_edges == 401) begin
                check("a_done_edge401", 32'(done_a), 32'd0);
                check("a_count_edge401", 32'(cnt_a), 32'd199);
            end
            if (done_edge_chk && a_edges == 402) begin
                check("a_done_edge402", 32'(done_a), 32'd1);
                check("a_count_edge402", 32'(cnt_a), 32'd200);
                check("a_state_edge402", 32'(state_a), 32'd3);
            end
            if (done_edge_chk && a_edges == 452) begin
                check("a_frozen_clk", 32'(clk_a), 32'd0);
                check("a_frozen_count", 32'(cnt_a), 32'd200);
                check("a_frozen_state", 32'(state_a), 32'd3);
            end
            if (rst_b) begin
                hi_len <= 0;
            end else if (clk_b[1]) begin
                hi_len <= hi_len + 1;
            end else begin
                if (hi_len != 0) check("b_pulse_width", 32'(hi_len >= 2), 32'd1);
                hi_len <= 0;
            end
        end
    end

    initial begin
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("a_rst_clk", 32'(clk_a), 32'd0);
        check("a_rst_sysr", 32'(sysr_a), 32'd1);
        check("a_rst_state", 32'(state_a), 32'd0);
        check("a_rst_count", 32'(cnt_a), 32'd0);
        check("a_rst_done", 32'(done_a), 32'd0);
        check("b_rst_clk", 32'(clk_b), 32'(4'b0101));
        cmp_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Edges counted from reset release.
        tick();                                     // edge 1
        check("a_e1_sysr", 32'(sysr_a), 32'd1);
        check("a_e1_state", 32'(state_a), 32'd0);
        tick();                                     // edge 2
        check("a_e2_sysr", 32'(sysr_a), 32'd0);
        check("a_e2_state", 32'(state_a), 32'd1);
        check("a_e2_clk", 32'(clk_a), 32'd0);
        check("b_e2_state", 32'(state_b), 32'd0);
        tick();                                     // edge 3
        check("a_e3_clk", 32'(clk_a), 32'(4'b1111));
        check("b_e3_state", 32'(state_b), 32'd1);
        check("b_e3_sysr", 32'(sysr_b), 32'd0);
        tick();                                     // edge 4
        check("a_e4_clk", 32'(clk_a), 32'd0);
        check("a_e4_count", 32'(cnt_a), 32'd1);
        check("b_e4_clk", 32'(clk_b), 32'(4'b0101));
        tick();                                     // edge 5
        check("b_e5_clk", 32'(clk_b), 32'(4'b1010));
        tick();                                     // edge 6
        tick();                                     // edge 7
        check("b_e7_count", 32'(cnt_b), 32'd1);
        check("b_e7_clk", 32'(clk_b), 32'(4'b0101));
        tick();                                     // edge 8
        @(negedge clock);
        halt_b = 1'b1;
        repeat (3) tick();                          // edges 9..11
        check("b_e11_state", 32'(state_b), 32'd2);
        check("b_e11_count", 32'(cnt_b), 32'd2);
        check("b_e11_clk", 32'(clk_b), 32'(4'b0101));
        repeat (4) tick();                          // edges 12..15
        check("b_e15_state", 32'(state_b), 32'd2);
        check("b_e15_count", 32'(cnt_b), 32'd2);
        @(negedge clock);
        halt_b = 1'b0;
        tick();                                     // edge 16
        check("b_e16_state", 32'(state_b), 32'd1);
        check("b_e16_count", 32'(cnt_b), 32'd2);
        check("b_e16_clk", 32'(clk_b), 32'(4'b0101));
        tick();                                     // edge 17
        tick();                                     // edge 18
        check("b_e18_clk", 32'(clk_b), 32'(4'b1010));

        // Random halts on B until one period short of the last.
        for (int k = 0; k < 2000 && cnt_b < 38; k++) begin
            @(negedge clock);
            halt_b = ($urandom_range(0, 9) < 4);
        end
        @(negedge clock);
        halt_b = 1'b0;
        check("b_reach_38", 32'(cnt_b >= 38), 32'd1);
        for (int k = 0; k < 100 && !(cnt_b == 39 && state_b == 2'd1); k++) tick();
        check("b_reach_39_run", 32'(cnt_b == 39 && state_b == 2'd1), 32'd1);
        @(negedge clock);
        halt_b = 1'b1;
        for (int k = 0; k < 10 && state_b == 2'd1; k++) tick();
        check("b_halt_vs_done_state", 32'(state_b), 32'd3);
        check("b_halt_vs_done_flag", 32'(done_b), 32'd1);
        check("b_halt_vs_done_count", 32'(cnt_b), 32'd40);
        @(negedge clock);
        halt_b = 1'b0;

        // Let A complete its run and sit frozen.
        for (int k = 0; k < 1000 && a_edges < 455; k++) tick();
        check("a_reach_455", 32'(a_edges >= 455), 32'd1);

        // Asynchronous reset of A in the middle of a run.
        done_edge_chk = 1'b0;
        @(negedge clock);
        rst_a = 1'b1;
        @(negedge clock);
        rst_a = 1'b0;
        for (int k = 0; k < 200 && cnt_a != 16'd37; k++) tick();
        check("a_reach_37", 32'(cnt_a), 32'd37);
        @(negedge clock);
        #2;
        rst_a = 1'b1;
        #1;
        check("a_async_state", 32'(state_a), 32'd0);
        check("a_async_sysr", 32'(sysr_a), 32'd1);
        check("a_async_count", 32'(cnt_a), 32'd0);
        check("a_async_done", 32'(done_a), 32'd0);
        check("a_async_clk", 32'(clk_a), 32'd0);
        @(negedge clock);
        rst_a = 1'b0;
        tick();
        check("a_rr_e1_sysr", 32'(sysr_a), 32'd1);
        tick();
        check("a_rr_e2_state", 32'(state_a), 32'd1);
        check("a_rr_e2_count", 32'(cnt_a), 32'd0);
        tick();
        tick();
        check("a_rr_e4_count", 32'(cnt_a), 32'd1);

        // Free random traffic on both instances with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clock);
            halt_a = ($urandom_range(0, 3) == 0);
            halt_b = ($urandom_range(0, 2) == 0);
            rst_a  = ($urandom_range(0, 299) == 0);
            rst_b  = ($urandom_range(0, 399) == 0);
        end
        @(negedge clock);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
